// File: rtl/gate_eval_pkg.sv
// Shared defaults and FIFO entry layout for the gate evaluation pipeline.
package gate_eval_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 16;

    // A FIFO entry is {x, y}, with x in the upper half and y in the lower half.
    function automatic int entry_w(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/gate_eval_fifo.sv
// Power-of-two FIFO with a combinational head read. The head reads as zero when the FIFO is empty.
module gate_eval_fifo #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;

    assign count = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two. A simultaneous push and pop leaves cnt unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/gate_eval_pipeline.sv
// Two-stage x=a&b, y=x|c evaluator with valid/ready flow control, an output FIFO,
// and a counter of y changes seen by the consumer.
module gate_eval_pipeline
    import gate_eval_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [WIDTH-1:0]       in_c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_x,
    output logic [WIDTH-1:0]       out_y,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [CNT_W-1:0]       y_change_count
);
    localparam int EW = entry_w(WIDTH);

    logic             s1_v, s2_v;
    logic [WIDTH-1:0] s1_x, s1_c;
    logic [WIDTH-1:0] s2_x, s2_y;
    logic [WIDTH-1:0] last_y;

    logic          fifo_full, fifo_empty;
    logic [EW-1:0] fifo_rdata;
    logic          in_fire, pop, push, fifo_ok, adv1, adv2;

    // A pop frees a slot on the same edge, so a full FIFO can still accept a push.
    // This creates a combinational path from out_ready to in_ready.
    assign pop      = out_valid & out_ready;
    assign fifo_ok  = ~fifo_full | pop;
    assign push     = s2_v & fifo_ok;
    assign adv2     = ~s2_v | push;
    assign adv1     = ~s1_v | adv2;
    assign in_ready = adv1;
    assign in_fire  = in_valid & in_ready;

    assign out_valid = ~fifo_empty;
    assign out_x     = fifo_rdata[EW-1 -: WIDTH];
    assign out_y     = fifo_rdata[WIDTH-1:0];

    // Stage 1: capture a&b and hold c. The stage holds its contents while stage 2 is stalled.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_v <= 1'b0;
            s1_x <= '0;
            s1_c <= '0;
        end else if (adv1) begin
            s1_v <= in_fire;
            if (in_fire) begin
                s1_x <= in_a & in_b;
                s1_c <= in_c;
            end
        end
    end

    // Stage 2: y is formed from the registered x, not from the raw inputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s2_v <= 1'b0;
            s2_x <= '0;
            s2_y <= '0;
        end else if (adv2) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_x <= s1_x;
                s2_y <= s1_x | s1_c;
            end
        end
    end

    gate_eval_fifo #(
        .DATA_W (EW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .wdata ({s2_x, s2_y}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Count consumed words whose y differs from the previously consumed y. The counter wraps.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            y_change_count <= '0;
            last_y         <= '0;
        end else if (pop) begin
            if (out_y != last_y) y_change_count <= y_change_count + 1'b1;
            last_y <= out_y;
        end
    end

endmodule
